// File: rtl/mem_pkg.sv
// Shared definitions for the sub-word data memory: access-size codes,
// clear-sequencer states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_t;

    // Halfwords need an even address and words a 4-byte boundary; 2'b11 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = (addr_lo != 2'b00);
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// Walks every word of the data memory writing zeros, one word per cycle,
// after reset or on request. Owns the clear FSM, its index and the busy flag.
module ram_clear_sequencer
    import mem_pkg::*;
#(
    parameter int NB_IDX = 7
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_clear_we,
    output logic [NB_IDX-1:0] o_clear_addr,
    output logic              o_clear_start,
    output clr_state_t        o_state
);

    localparam logic [NB_IDX-1:0] LAST_IDX = '1;

    clr_state_t        state;
    logic [NB_IDX-1:0] clr_idx;
    logic              busy;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    // The last word is written on this edge, so busy drops together with it.
                    if (clr_idx == LAST_IDX) begin
                        state   <= S_IDLE;
                        clr_idx <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_clear) begin
                        state   <= S_CLEAR;
                        clr_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_CLEAR;
                    clr_idx <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy        = busy;
    assign o_clear_we    = (state == S_CLEAR);
    assign o_clear_addr  = clr_idx;
    assign o_clear_start = (state == S_IDLE) && i_clear;
    assign o_state       = state;

endmodule

// File: rtl/data_mem_subword.sv
// Big-endian byte-addressable data memory for the MEM stage with byte/half/word
// loads and stores, sign/zero extension, misalignment flagging and a sequenced clear.
module data_mem_subword
    import mem_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 9,
    parameter int NB_BYTE = 8,
    parameter int NB_SIZE = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clear,
    input  logic               i_we,
    input  logic [NB_SIZE-1:0] i_size,
    input  logic               i_unsigned,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_data_in,
    output logic [NB_DATA-1:0] o_data_out,
    output logic               o_misaligned,
    output logic               o_err,
    output logic               o_busy
);

    localparam int NB_LANES    = NB_DATA / NB_BYTE;
    localparam int NB_LANE_SEL = $clog2(NB_LANES);
    localparam int NB_IDX      = NB_ADDR - NB_LANE_SEL;
    localparam int N_WORDS     = 2 ** NB_IDX;

    // Word-organised storage; byte lane 3 (bits 31:24) holds the lowest byte address.
    logic [NB_DATA-1:0] mem [N_WORDS];

    logic               busy;
    logic               clear_we;
    logic [NB_IDX-1:0]  clear_addr;
    logic               clear_start;
    clr_state_t         seq_state;

    logic [NB_IDX-1:0]      word_idx;
    logic [NB_LANE_SEL-1:0] lane;
    logic                   misaligned;

    logic [NB_LANES-1:0] store_be;
    logic [NB_DATA-1:0]  store_data;
    logic                wr_en;
    logic [NB_IDX-1:0]   wr_idx;
    logic [NB_LANES-1:0] wr_be;
    logic [NB_DATA-1:0]  wr_data;

    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [NB_DATA-1:0] load_data;
    logic               err;

    ram_clear_sequencer #(
        .NB_IDX(NB_IDX)
    ) u_clear_seq (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (i_clear),
        .o_busy       (busy),
        .o_clear_we   (clear_we),
        .o_clear_addr (clear_addr),
        .o_clear_start(clear_start),
        .o_state      (seq_state)
    );

    assign word_idx   = i_addr[NB_ADDR-1:NB_LANE_SEL];
    assign lane       = i_addr[NB_LANE_SEL-1:0];
    assign misaligned = is_misaligned(i_size, lane);

    // Store data is replicated across lanes so the byte enables alone place it.
    always_comb begin
        store_be   = '0;
        store_data = '0;
        case (i_size)
            SIZE_BYTE: begin
                store_be   = 4'b1000 >> lane;
                store_data = {4{i_data_in[7:0]}};
            end
            SIZE_HALF: begin
                store_be   = lane[1] ? 4'b0011 : 4'b1100;
                store_data = {2{i_data_in[15:0]}};
            end
            SIZE_WORD: begin
                store_be   = 4'b1111;
                store_data = i_data_in;
            end
            default: begin
                store_be   = '0;
                store_data = '0;
            end
        endcase
    end

    // The clear port owns the array while the sequencer is running.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_be   = '0;
        wr_data = '0;
        if (clear_we) begin
            wr_en   = 1'b1;
            wr_idx  = clear_addr;
            wr_be   = '1;
            wr_data = '0;
        end else if ((seq_state == S_IDLE) && i_we && !misaligned) begin
            wr_en   = 1'b1;
            wr_idx  = word_idx;
            wr_be   = store_be;
            wr_data = store_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB_LANES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][b*NB_BYTE +: NB_BYTE] <= wr_data[b*NB_BYTE +: NB_BYTE];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[word_idx];
        case (lane)
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half   = lane[1] ? rd_word[15:0] : rd_word[31:16];
        load_data = '0;
        if (!busy && !misaligned) begin
            case (i_size)
                SIZE_BYTE: load_data = {{(NB_DATA-8){~i_unsigned & rd_byte[7]}}, rd_byte};
                SIZE_HALF: load_data = {{(NB_DATA-16){~i_unsigned & rd_half[15]}}, rd_half};
                SIZE_WORD: load_data = rd_word;
                default:   load_data = '0;
            endcase
        end
    end

    // Sticky store-error flag, cleared only by reset or a new clear sequence.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err <= 1'b0;
        end else if (clear_start) begin
            err <= 1'b0;
        end else if (!busy && i_we && misaligned) begin
            err <= 1'b1;
        end
    end

    assign o_data_out   = load_data;
    assign o_misaligned = misaligned;
    assign o_err        = err;
    assign o_busy       = busy;

endmodule
